pipeline_hazard_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS 32-bit pipeline. It drives the enable and bubble inputs of the PC register and the IF/ID, ID/EX and EX/MEM buffers. It resolves three hazard classes:
- multi-cycle data-memory waits, which freeze the pipe;
- taken branches and jumps resolved in EX, which flush the younger stages;
- load-use dependencies, which insert one bubble.

A sticky timeout error stops the pipe permanently if memory never answers.

---
 rtl/mips_pipe_pkg.sv | 17 +
 rtl/load_use_detect.sv | 30 +++
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline control blocks.
//   hz_state_t : hazard sequencer states (RUN, MEM_WAIT, HALT)
//   REG_W      : register-index width
//   ZERO_REG   : hard-wired zero register index (never a real dependency)
package mips_pipe_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } hz_state_t;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector.
// Flags a hazard when the instruction in EX is a load whose destination (ex_rt)
// is read by the instruction in decode. Register 0 never creates a hazard.
//   id_rs, id_rt  : source fields of the decode instruction
//   id_uses_rt    : decode instruction actually reads rt
//   ex_mem_read   : EX instruction is a load
//   ex_rt         : load destination held in ID/EX
//   hazard        : one-bubble stall required
module load_use_detect #(
  parameter int unsigned REG_W = mips_pipe_pkg::REG_W
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  output logic             hazard
);
  import mips_pipe_pkg::*;

  logic rs_match;
  logic rt_match;

  always_comb begin
    rs_match = (ex_rt == id_rs);
    rt_match = id_uses_rt && (ex_rt == id_rt);
    hazard   = ex_mem_read && (ex_rt != REG_W'(ZERO_REG)) && (rs_match || rt_match);
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS pipeline.
// Drives PC / IF/ID / ID/EX / EX/MEM enables and bubble controls.
// Priority within a cycle: memory freeze > control flush > load-use bubble.
// Outputs are Mealy (state + current inputs) so no latency is added to the pipe.
//   clk, rst_n           : clock, async active-low reset
//   id_rs/id_rt/id_uses_rt, ex_mem_read/ex_rt : load-use detection inputs
//   ex_branch_taken, ex_jump                  : control transfer resolved in EX
//   mem_access, mem_ready                     : data-memory handshake
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en : pipe controls
//   timeout_err          : sticky, set when memory never answers
//   stall_count, flush_count : saturating performance counters
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_W    = mips_pipe_pkg::REG_W,
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_branch_taken,
  input  logic             ex_jump,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);
  import mips_pipe_pkg::*;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  hz_state_t  state;
  logic [7:0] wait_cnt;
  // Set on the first clock edge after reset release; keeps every control
  // output low until then, so the pipe starts on a clean edge.
  logic       live;

  logic lu_hazard;
  logic freeze;
  logic ctrl_flush;
  logic lu_stall;

  load_use_detect #(.REG_W(REG_W)) u_lud (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .hazard      (lu_hazard)
  );

  always_comb begin
    freeze     = 1'b0;
    ctrl_flush = 1'b0;
    lu_stall   = 1'b0;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;

    if (live && (state != HALT)) begin
      if (state == MEM_WAIT) freeze = !mem_ready;
      else                   freeze = mem_access && !mem_ready;

      if (!freeze) begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        idex_en  = 1'b1;
        exmem_en = 1'b1;
        // A branch captured while frozen is still in ID/EX, so it flushes
        // here on the release cycle and masks any load-use bubble.
        if (ex_branch_taken || ex_jump) begin
          ctrl_flush = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu_hazard) begin
          lu_stall   = 1'b1;
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live        <= 1'b0;
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      live <= 1'b1;
      if (live) begin
        unique case (state)
          RUN: begin
            if (freeze) begin
              state    <= MEM_WAIT;
              wait_cnt <= 8'd1;
            end
          end
          MEM_WAIT: begin
            if (mem_ready) begin
              state    <= RUN;
              wait_cnt <= '0;
            end else if (wait_cnt == WAIT_LAST) begin
              state       <= HALT;
              timeout_err <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          HALT: begin
            state <= HALT;
          end
          default: begin
            state <= RUN;
          end
        endcase

        if ((freeze || lu_stall) && (stall_count != '1))
          stall_count <= stall_count + 1'b1;
        if (ctrl_flush && (flush_count != '1))
          flush_count <= flush_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_jump;
  logic       mem_access, mem_ready;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, timeout_err;
  logic [15:0] stall_count, flush_count;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_timeout_err;
  logic [3:0]  s_stall_count, s_flush_count;

  int n_asserts = 0;
  int n_fails   = 0;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  localparam logic [5:0] OFF    = 6'b000000;
  localparam logic [5:0] NORMAL = 6'b110101;
  localparam logic [5:0] FLUSH  = 6'b111111;
  localparam logic [5:0] LU     = 6'b000111;

  logic [5:0] ctl;
  assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_W(5), .MAX_WAIT(16), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .timeout_err(timeout_err),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.REG_W(5), .MAX_WAIT(16), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_jump(ex_jump), .mem_access(mem_access), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
    .idex_flush(s_idex_flush), .exmem_en(s_exmem_en), .timeout_err(s_timeout_err),
    .stall_count(s_stall_count), .flush_count(s_flush_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_jump = 1'b0;
    mem_access = 1'b0; mem_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();

    // Reset state
    #2;
    chk("rst_ctl", 32'(ctl), 32'(OFF));
    chk("rst_stall", 32'(stall_count), 0);
    chk("rst_flush", 32'(flush_count), 0);
    chk("rst_terr", 32'(timeout_err), 0);
    @(posedge clk); #1;
    chk("rst_ctl_edge", 32'(ctl), 32'(OFF));
    rst_n = 1'b1;
    #1;
    chk("pre_first_edge", 32'(ctl), 32'(OFF));
    step();
    chk("first_edge_normal", 32'(ctl), 32'(NORMAL));

    // Saturation: 20 held load-use cycles
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    chk("sat_lu_ctl", 32'(ctl), 32'(LU));
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 14) chk("sat_reach15", 32'(s_stall_count), 15);
    end
    chk("sat_hold15", 32'(s_stall_count), 15);
    chk("nosat_20", 32'(stall_count), 20);

    // Reset pulse mid-cycle clears counters asynchronously
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst2_stall", 32'(stall_count), 0);
    chk("rst2_sat", 32'(s_stall_count), 0);
    chk("rst2_ctl", 32'(ctl), 32'(OFF));
    rst_n = 1'b1;
    step();
    chk("rst2_normal", 32'(ctl), 32'(NORMAL));

    // Load-use via rs
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; id_rt = 5'd3;
    #1;
    chk("lu_rs_ctl", 32'(ctl), 32'(LU));
    step();
    ex_mem_read = 1'b0;
    #1;
    chk("lu_after_ctl", 32'(ctl), 32'(NORMAL));
    chk("lu_stall1", 32'(stall_count), 1);
    // Load-use via rt, only if rt is used
    ex_mem_read = 1'b1; ex_rt = 5'd3; id_rs = 5'd9; id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_ctl", 32'(ctl), 32'(LU));
    id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", 32'(ctl), 32'(NORMAL));
    // Register 0 never stalls
    ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b1;
    #1;
    chk("lu_r0_ctl", 32'(ctl), 32'(NORMAL));
    step();
    chk("lu_r0_stall", 32'(stall_count), 1);
    clear_inputs();

    // Taken branch
    ex_branch_taken = 1'b1;
    #1;
    chk("br_ctl", 32'(ctl), 32'(FLUSH));
    step();
    ex_branch_taken = 1'b0;
    #1;
    chk("br_after_ctl", 32'(ctl), 32'(NORMAL));
    chk("br_flush1", 32'(flush_count), 1);

    // Jump beats a simultaneous load-use
    ex_jump = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd4; id_rs = 5'd4;
    #1;
    chk("jmp_lu_ctl", 32'(ctl), 32'(FLUSH));
    step();
    clear_inputs();
    #1;
    chk("jmp_flush2", 32'(flush_count), 2);
    chk("jmp_stall1", 32'(stall_count), 1);

    // Memory wait: 3 frozen cycles then ready
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("mw_frozen%0d", i), 32'(ctl), 32'(OFF));
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("mw_release", 32'(ctl), 32'(NORMAL));
    step();
    chk("mw_stall4", 32'(stall_count), 4);
    mem_access = 1'b1; mem_ready = 1'b1;
    #1;
    chk("mw_run_again", 32'(ctl), 32'(NORMAL));
    clear_inputs();
    step();

    // Branch + load-use during a 2-cycle freeze
    mem_access = 1'b1; mem_ready = 1'b0;
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk($sformatf("sim_frozen%0d", i), 32'(ctl), 32'(OFF));
      step();
    end
    mem_ready = 1'b1;
    #1;
    chk("sim_release", 32'(ctl), 32'(FLUSH));
    step();
    clear_inputs();
    #1;
    chk("sim_flush3", 32'(flush_count), 3);
    chk("sim_stall6", 32'(stall_count), 6);

    // Timeout after 16 frozen cycles
    mem_access = 1'b1; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (i == 0 || i == 15) chk($sformatf("to_frozen%0d", i), 32'(ctl), 32'(OFF));
      if (i == 15) chk("to_not_yet", 32'(timeout_err), 0);
      step();
    end
    chk("to_terr", 32'(timeout_err), 1);
    chk("to_stall22", 32'(stall_count), 22);
    mem_ready = 1'b1; ex_branch_taken = 1'b1;
    #1;
    chk("halt_ctl", 32'(ctl), 32'(OFF));
    step();
    chk("halt_terr_held", 32'(timeout_err), 1);
    chk("halt_flush3", 32'(flush_count), 3);
    clear_inputs();
    rst_n = 1'b0;
    #1;
    chk("halt_rst_terr", 32'(timeout_err), 0);
    rst_n = 1'b1;
    step();
    chk("halt_rst_run", 32'(ctl), 32'(NORMAL));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
